cv_ctrl_port: RTL and testbench
===============================

# cv_ctrl_port

Multi-port ColecoVision controller interface for the console's controller bus, one instance per console. It turns per-player button vectors into the registered, active-low controller-port pins the console reads: direction lines, fire, and the quadrature spinner lines. The keypad/joystick half-select is honoured per port, with 1 to 4 ports. Each port also has a rate-limited spinner quadrature generator, used by Super Action / driving-module titles, fed by signed motion deltas.

## Interface
- NUM_PORTS, 2, number of controller ports (1..4)
- SPIN_W, 8, width of signed spinner delta per strobe
- QUAD_DIV, 64, ce_i pulses per quadrature step (≥2)
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- ce_i  in  1  10.7 MHz clock enable; gates the spinner prescaler only
- keypad_i  in  NUM_PORTS*20  per port p at bits [20p+19:20p], active high
  - bits 0..9: digits 0..9; 10: *; 11: #
  - 12: purple; 13: blue
  - 14..17: up, down, left, right
  - 18: fire 1; 19: fire 2
- sel_kp_n_i  in  NUM_PORTS  keypad half select (console p5), active low
- sel_joy_n_i  in  NUM_PORTS  joystick half select (console p8), active low
- spin_en_i  in  NUM_PORTS  enable spinner for port
- spin_i  in  NUM_PORTS*SPIN_W  signed two's-complement delta per port
- spin_stb_i  in  NUM_PORTS  one-cycle strobe, accepts spin_i for port
- ctrl_o  out  NUM_PORTS*4  pins p1..p4 per port, bit [4p+3] = p1, active low
- fire_n_o  out  NUM_PORTS  pin p6, active low
- quad_o  out  NUM_PORTS*2  {p7,p9} quadrature A/B per port

## Operation
- Keypad half: when sel_kp_n_i=0, p1..p4 carry a priority encoding of bits 0..13. The lowest set index wins:
  - 0→0011, 1→1110, 2→1101, 3→0110, 4→0001
  - 5→1001, 6→0111, 7→1100, 8→1000, 9→1011
  - *→1010, #→0101, purple→0100, blue→0010
  - none→1111
  - Keypad-half fire = ~bit19.
- Joystick half: when sel_joy_n_i=0, p1..p4 = ~{up,down,left,right}; joystick-half fire = ~bit18.
- A half that is not selected contributes 1111 and fire 1.
- Outputs are the bitwise AND of the two halves, so both halves selected wire-AND together.
- Spinner accumulator per port:
  - Signed, SPIN_W+4 bits, saturating at the signed max/min.
  - On spin_stb_i with spin_en_i=1, add the sign-extended spin_i.
- Prescaler: a shared counter of ce_i pulses. It emits a one-cycle tick when it reaches QUAD_DIV-1, then wraps to 0.
- Quadrature stepping on each tick, per enabled port:
  - acc>0: one forward step, acc−1.
  - acc<0: one reverse step, acc+1.
  - acc=0: hold.
- Gray phase sequence:
  - Forward: 11→10→00→01→11.
  - Reverse is the inverse sequence.
  - Exactly one quad bit changes per step.
- Strobe and tick in the same cycle: acc_next = sat(acc + delta − step), where step is ±1 or 0 and is decided from the pre-update acc.
- spin_en_i=0: acc cleared to 0, phase forced to 11, strobes ignored. Re-enabling starts from 11 with acc=0.

## Timing
- Reset (asynchronous assert, released on clock):
  - ctrl_o all 1, fire_n_o all 1, quad_o all 11.
  - Accumulators 0, prescaler 0.
- ctrl_o and fire_n_o are registered: a change on sel_*_i or keypad_i appears one clk_i edge later. These outputs are not gated by ce_i.
- quad_o is registered and updates on the edge after the tick cycle.
- Max step rate is one per QUAD_DIV ce_i pulses. No output glitches.
- Spinner latency: a strobe of +1 when acc=0 changes quad_o no later than QUAD_DIV ce_i pulses plus 1 clk after the strobe.
- Reset asserted mid-step abandons the step. The phase returns to 11 and pending motion is discarded.

## Test plan
- Reset → ctrl_o=all 1, fire_n_o=all 1, quad_o=11 per port; release, all inputs 0 → unchanged.
- Port 0 keypad: sel_kp_n=0, sel_joy_n=1.
  - Bits 3 and 7 set → ctrl_o[3:0]=0110 one clk later.
  - Only bit 13 set → 0010.
  - Bit 19 set → fire_n_o[0]=0.
- Port 1 joystick: sel_joy_n=0, up+right and fire1 set → ctrl_o[7:4]=0110, fire_n_o[1]=0. Port 0 is unaffected.
- Both halves selected, digit 0 plus left → ctrl_o = 0011 & 1101 = 0001.
- Spinner, QUAD_DIV=4, spin_en=1:
  - Strobe +3 → quad_o 11→10→00→01 on three successive ticks, then holds.
  - Strobe −2 → 01→00→10.
- Saturation and disable:
  - Repeated strobes of +127 → acc stops at the signed max of SPIN_W+4.
  - Drop spin_en → quad_o=11 next clk, acc=0.
  - Strobe coinciding with a tick obeys acc+delta−step.

Source files
------------

// File: rtl/cv_ctrl_port.sv
// cv_ctrl_port: ColecoVision controller-port emulation for 1..4 ports.
// Converts per-player button vectors into registered active-low port pins
// and drives a rate-limited quadrature spinner from signed motion deltas.
module cv_ctrl_port #(
    parameter int NUM_PORTS = 2,
    parameter int SPIN_W    = 8,
    parameter int QUAD_DIV  = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        ce_i,
    input  logic [NUM_PORTS*20-1:0]     keypad_i,
    input  logic [NUM_PORTS-1:0]        sel_kp_n_i,
    input  logic [NUM_PORTS-1:0]        sel_joy_n_i,
    input  logic [NUM_PORTS-1:0]        spin_en_i,
    input  logic [NUM_PORTS*SPIN_W-1:0] spin_i,
    input  logic [NUM_PORTS-1:0]        spin_stb_i,
    output logic [NUM_PORTS*4-1:0]      ctrl_o,
    output logic [NUM_PORTS-1:0]        fire_n_o,
    output logic [NUM_PORTS*2-1:0]      quad_o
);

    localparam int ACC_W = SPIN_W + 4;
    localparam int SUM_W = ACC_W + 2;
    localparam int PW    = (QUAD_DIV > 2) ? $clog2(QUAD_DIV) : 1;

    // Keypad code for one pressed key index; pins ordered {p1,p2,p3,p4}.
    function automatic logic [3:0] key_code(input int idx);
        case (idx)
            0:       key_code = 4'b0011;
            1:       key_code = 4'b1110;
            2:       key_code = 4'b1101;
            3:       key_code = 4'b0110;
            4:       key_code = 4'b0001;
            5:       key_code = 4'b1001;
            6:       key_code = 4'b0111;
            7:       key_code = 4'b1100;
            8:       key_code = 4'b1000;
            9:       key_code = 4'b1011;
            10:      key_code = 4'b1010;
            11:      key_code = 4'b0101;
            12:      key_code = 4'b0100;
            13:      key_code = 4'b0010;
            default: key_code = 4'b1111;
        endcase
    endfunction

    // Gray phase advance: forward 11->10->00->01->11, reverse is the inverse.
    function automatic logic [1:0] phase_fwd(input logic [1:0] ph);
        case (ph)
            2'b11:   phase_fwd = 2'b10;
            2'b10:   phase_fwd = 2'b00;
            2'b00:   phase_fwd = 2'b01;
            default: phase_fwd = 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] phase_rev(input logic [1:0] ph);
        case (ph)
            2'b11:   phase_rev = 2'b01;
            2'b01:   phase_rev = 2'b00;
            2'b00:   phase_rev = 2'b10;
            default: phase_rev = 2'b11;
        endcase
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // Shared prescaler: counts ce_i pulses, one-cycle tick on the last count.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (ce_i) begin
            if (presc_q == PW'(QUAD_DIV - 1)) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) presc_q <= '0;
        else            presc_q <= presc_d;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [19:0]       kp;
            logic [SPIN_W-1:0] delta;
            logic [3:0]        ctrl_q, ctrl_d;
            logic              fire_q, fire_d;
            logic [ACC_W-1:0]  acc_q, acc_d;
            logic [1:0]        phase_q, phase_d;
            logic [3:0]        kp_half;
            logic [3:0]        joy_half;
            logic [SUM_W-1:0]  sum;

            assign kp    = keypad_i[20*gi +: 20];
            assign delta = spin_i[SPIN_W*gi +: SPIN_W];

            assign ctrl_o[4*gi +: 4] = ctrl_q;
            assign fire_n_o[gi]      = fire_q;
            assign quad_o[2*gi +: 2] = phase_q;

            // Pin levels: each half contributes only when selected; the halves wire-AND.
            always_comb begin
                kp_half  = 4'b1111;
                joy_half = 4'b1111;
                fire_d   = 1'b1;
                if (!sel_kp_n_i[gi]) begin
                    // Scan downwards so the lowest pressed index ends up winning.
                    for (int k = 13; k >= 0; k--) begin
                        if (kp[k]) kp_half = key_code(k);
                    end
                    fire_d = fire_d & ~kp[19];
                end
                if (!sel_joy_n_i[gi]) begin
                    joy_half = ~kp[17:14] == 4'b0 ? 4'b0 : ~{kp[14], kp[15], kp[16], kp[17]};
                    fire_d   = fire_d & ~kp[18];
                end
                ctrl_d = kp_half & joy_half;
            end

            // Spinner: accumulate deltas, emit one step per tick toward zero, saturate.
            always_comb begin
                sum     = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
                phase_d = phase_q;
                if (spin_stb_i[gi]) begin
                    sum = sum + {{(SUM_W-SPIN_W){delta[SPIN_W-1]}}, delta};
                end
                // Step direction comes from the accumulator before this cycle's delta.
                if (tick) begin
                    if (!acc_q[ACC_W-1] && (acc_q != '0)) begin
                        sum     = sum - SUM_W'(1);
                        phase_d = phase_fwd(phase_q);
                    end else if (acc_q[ACC_W-1]) begin
                        sum     = sum + SUM_W'(1);
                        phase_d = phase_rev(phase_q);
                    end
                end
                // Saturate when the extra headroom bits disagree with the result sign.
                if (sum[SUM_W-1:ACC_W-1] == '0 || sum[SUM_W-1:ACC_W-1] == '1) begin
                    acc_d = sum[ACC_W-1:0];
                end else if (sum[SUM_W-1]) begin
                    acc_d = {1'b1, {(ACC_W-1){1'b0}}};
                end else begin
                    acc_d = {1'b0, {(ACC_W-1){1'b1}}};
                end
                if (!spin_en_i[gi]) begin
                    acc_d   = '0;
                    phase_d = 2'b11;
                end
            end

            // Port registers; reset idles all pins high and drops pending motion.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    ctrl_q  <= 4'b1111;
                    fire_q  <= 1'b1;
                    acc_q   <= '0;
                    phase_q <= 2'b11;
                end else begin
                    ctrl_q  <= ctrl_d;
                    fire_q  <= fire_d;
                    acc_q   <= acc_d;
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cv_ctrl_port.sv
// tb_cv_ctrl_port: directed vectors for cv_ctrl_port (2 ports, QUAD_DIV=4).
module tb_cv_ctrl_port;

    localparam int NP = 2;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic [39:0]   keypad;
    logic [1:0]    sel_kp_n;
    logic [1:0]    sel_joy_n;
    logic [1:0]    spin_en;
    logic [15:0]   spin;
    logic [1:0]    spin_stb;
    logic [7:0]    ctrl;
    logic [1:0]    fire_n;
    logic [3:0]    quad;

    int n_vec = 0;
    int n_bad = 0;

    cv_ctrl_port #(.NUM_PORTS(NP), .SPIN_W(SW), .QUAD_DIV(4)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .ce_i        (ce),
        .keypad_i    (keypad),
        .sel_kp_n_i  (sel_kp_n),
        .sel_joy_n_i (sel_joy_n),
        .spin_en_i   (spin_en),
        .spin_i      (spin),
        .spin_stb_i  (spin_stb),
        .ctrl_o      (ctrl),
        .fire_n_o    (fire_n),
        .quad_o      (quad)
    );

    always #5 clk = ~clk;

    logic [3:0] kp_tab [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                                4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                                4'b1010, 4'b0101, 4'b0100, 4'b0010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ce(input int n);
        ce = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        ce = 1'b0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [1:0] ph);
        case (ph)
            2'b11:   exp_fwd = 2'b10;
            2'b10:   exp_fwd = 2'b00;
            2'b00:   exp_fwd = 2'b01;
            default: exp_fwd = 2'b11;
        endcase
    endfunction

    // Runs n ce cycles and counts port-0 quadrature steps and non-forward steps.
    task automatic run_count(input int n, output int cnt, output int bad);
        logic [1:0] prev;
        cnt = 0;
        bad = 0;
        ce  = 1'b1;
        for (int i = 0; i < n; i++) begin
            prev = quad[1:0];
            cyc();
            if (quad[1:0] !== prev) begin
                cnt++;
                if (quad[1:0] !== exp_fwd(prev)) bad++;
            end
        end
        ce = 1'b0;
    endtask

    task automatic strobe0(input logic [7:0] d);
        spin[7:0] = d;
        spin_stb  = 2'b01;
        cyc();
        spin_stb  = 2'b00;
        spin[7:0] = 8'h00;
    endtask

    initial begin
        int cnt;
        int bad;
        reset_n   = 1'b0;
        ce        = 1'b0;
        keypad    = '0;
        sel_kp_n  = 2'b11;
        sel_joy_n = 2'b11;
        spin_en   = 2'b00;
        spin      = '0;
        spin_stb  = 2'b00;
        cyc();
        cyc();
        check("rst_ctrl", 32'(ctrl), 32'hFF);
        check("rst_fire", 32'(fire_n), 32'h3);
        check("rst_quad", 32'(quad), 32'hF);

        // Release with every input low: both halves selected, nothing pressed.
        reset_n   = 1'b1;
        sel_kp_n  = 2'b00;
        sel_joy_n = 2'b00;
        cyc();
        cyc();
        check("idle_ctrl", 32'(ctrl), 32'hFF);
        check("idle_fire", 32'(fire_n), 32'h3);
        check("idle_quad", 32'(quad), 32'hF);

        // Port 0 keypad only.
        sel_kp_n  = 2'b10;
        sel_joy_n = 2'b11;
        keypad    = '0;
        keypad[3] = 1'b1;
        keypad[7] = 1'b1;
        cyc();
        check("kp_3and7", 32'(ctrl[3:0]), 32'h6);
        for (int k = 0; k < 14; k++) begin
            keypad    = '0;
            keypad[k] = 1'b1;
            cyc();
            check($sformatf("kp_key%0d", k), 32'(ctrl[3:0]), 32'(kp_tab[k]));
        end
        keypad     = '0;
        keypad[19] = 1'b1;
        cyc();
        check("kp_fire2", 32'(fire_n), 32'h2);
        check("kp_fire2_ctrl", 32'(ctrl), 32'hFF);
        keypad     = '0;
        keypad[18] = 1'b1;
        cyc();
        check("kp_fire1_ignored", 32'(fire_n), 32'h3);

        // Port 1 joystick only; port 0 keypad half selected with nothing pressed.
        keypad      = '0;
        keypad[34]  = 1'b1;   // up
        keypad[37]  = 1'b1;   // right
        keypad[38]  = 1'b1;   // fire 1
        keypad[20]  = 1'b1;   // digit 0, keypad half not selected
        sel_kp_n    = 2'b10;
        sel_joy_n   = 2'b01;
        cyc();
        check("joy_p1_ctrl", 32'(ctrl[7:4]), 32'h6);
        check("joy_p1_fire", 32'(fire_n[1]), 32'h0);
        check("joy_p0_ctrl", 32'(ctrl[3:0]), 32'hF);
        check("joy_p0_fire", 32'(fire_n[0]), 32'h1);

        // Both halves on port 0: digit 0 AND left.
        keypad     = '0;
        keypad[0]  = 1'b1;
        keypad[16] = 1'b1;
        sel_kp_n   = 2'b10;
        sel_joy_n  = 2'b10;
        cyc();
        check("both_ctrl", 32'(ctrl[3:0]), 32'h1);

        keypad    = '0;
        sel_kp_n  = 2'b11;
        sel_joy_n = 2'b11;
        cyc();
        check("desel_ctrl", 32'(ctrl), 32'hFF);

        // Spinner on port 0; prescaler is still at 0 since ce has been low.
        spin_en = 2'b01;
        cyc();
        strobe0(8'd3);
        run_ce(4);
        check("spin_s1", 32'(quad), 32'hE);
        run_ce(4);
        check("spin_s2", 32'(quad), 32'hC);
        run_ce(4);
        check("spin_s3", 32'(quad), 32'hD);
        run_ce(4);
        check("spin_hold", 32'(quad), 32'hD);

        strobe0(8'hFE);
        run_ce(4);
        check("spin_r1", 32'(quad[1:0]), 32'h0);
        run_ce(4);
        check("spin_r2", 32'(quad[1:0]), 32'h2);
        run_ce(4);
        check("spin_rhold", 32'(quad[1:0]), 32'h2);

        // Disable mid-motion, then show motion and disabled strobes are discarded.
        strobe0(8'd5);
        run_ce(4);
        check("dis_pre", 32'(quad[1:0]), 32'h0);
        spin_en = 2'b00;
        cyc();
        check("dis_quad", 32'(quad[1:0]), 32'h3);
        strobe0(8'd3);
        spin_en = 2'b01;
        run_count(16, cnt, bad);
        check("dis_nosteps", 32'(cnt), 32'd0);

        // Saturation: 17 x 127 = 2159 clamps at 2047.
        for (int i = 0; i < 17; i++) strobe0(8'd127);
        run_count(2047*4 + 40, cnt, bad);
        check("sat_steps", 32'(cnt), 32'd2047);
        check("sat_gray", 32'(bad), 32'd0);
        check("sat_phase", 32'(quad[1:0]), 32'h1);

        // Strobe on the tick cycle: acc 2 + 5 - 1 = 6, step taken in that cycle.
        strobe0(8'd2);
        run_ce(3);
        check("co_pre", 32'(quad[1:0]), 32'h1);
        ce        = 1'b1;
        spin[7:0] = 8'd5;
        spin_stb  = 2'b01;
        cyc();
        ce        = 1'b0;
        spin_stb  = 2'b00;
        spin[7:0] = 8'd0;
        check("co_step", 32'(quad[1:0]), 32'h3);
        run_count(40, cnt, bad);
        check("co_steps", 32'(cnt), 32'd6);
        check("co_phase", 32'(quad[1:0]), 32'h0);

        // Asynchronous reset in the middle of a step window.
        strobe0(8'd3);
        run_ce(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_quad", 32'(quad), 32'hF);
        check("arst_fire", 32'(fire_n), 32'h3);
        cyc();
        reset_n = 1'b1;
        cyc();
        run_count(16, cnt, bad);
        check("arst_nosteps", 32'(cnt), 32'd0);
        check("arst_phase", 32'(quad), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
